step_pulse_gen: RTL and testbench
=================================

Name: step_pulse_gen

Overview:
Downstream stage of the tracking-mode controller. Consumes the required step period n, the direction bit and the stepper-enable bit, and produces STEP/DIR signals for the external stepper driver. Enforces fixed pulse width, DIR setup time before the first step after a reversal, and a minimum step period. Keeps a signed step-position counter for diagnostics.

Parameters:
WIDTH_WORK, 16, width of period input
PRESCALE_LOG2, 3, step period in clk cycles = period << PRESCALE_LOG2
PULSE_W, 100, STEP high time in clk cycles (2 us at 50 MHz)
DIR_SETUP, 250, clk cycles from dir_out change to next STEP rise (5 us)
MIN_PERIOD, 200, minimum step period in clk cycles; requirement: MIN_PERIOD >= PULSE_W+1
POS_WIDTH, 32, width of position counter

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-high
en  in  1  stepper enable from controller, clk-synchronous
dir  in  1  requested direction from controller, clk-synchronous
period  in  WIDTH_WORK  requested period n; written from the data_valid domain, not clk-synchronous
step_out  out  1  STEP to driver
dir_out  out  1  DIR to driver
busy  out  1  high in any state other than IDLE
step_done  out  1  one-cycle strobe at the end of each full step cycle
pos  out  POS_WIDTH  signed step count: +1 per step with dir_out=1, -1 with dir_out=0

Behaviour:
- Reset values: step_out=0, dir_out=0, busy=0, step_done=0, pos=0, period_s=0, state=IDLE. Reset mid-pulse drops step_out immediately.
- Period capture: period is sampled every clk into p0. period_s <= p0 only when p0 equals the previous sample. Latency is 2 clk from a stable change.
- Effective period: T = max(period_s << PRESCALE_LOG2, MIN_PERIOD). Compute at WIDTH_WORK+PRESCALE_LOG2 bits with no truncation.
- T is latched into t_q on every entry to HIGH. A period change never alters a step already in progress.
- Start condition go = en && (period_s != 0).
- IDLE:
  - go && dir==dir_out: go to HIGH.
  - go && dir!=dir_out: set dir_out<=dir, then go to DIR_SETUP.
  - Otherwise stay in IDLE.
- DIR_SETUP: holds for DIR_SETUP cycles, then goes to HIGH. If en falls, go to IDLE; dir_out keeps its new value.
- HIGH:
  - step_out=1 for exactly PULSE_W cycles.
  - pos updates on the entry cycle.
  - en falling never truncates the pulse.
- LOW:
  - step_out=0 for t_q-PULSE_W cycles.
  - Last cycle: step_done=1.
  - Next state from go/dir: go and dir unchanged → HIGH (back-to-back; STEP rise-to-rise = t_q exactly). go and dir changed → dir_out<=dir, then DIR_SETUP. Not go → IDLE.
- dir_out changes only on IDLE→DIR_SETUP or LOW→DIR_SETUP, never while step_out=1.
- All outputs are registered. step_out rises 1 clk after go is seen in IDLE.
- pos wraps modulo 2^POS_WIDTH.
- period_s==0 means "hold": no new steps; an in-flight step completes.
- Counter: a single down-counter shared by DIR_SETUP, HIGH and LOW, width WIDTH_WORK+PRESCALE_LOG2.

Decomposition:
- Package stepper_pkg: state enum {IDLE, DIR_SETUP, HIGH, LOW} (2 bits), and a function computing T (shift plus clamp).
- Sub-module step_period_capture: the 2-sample stability filter producing period_s.

Test Plan:
Bench parameters: PRESCALE_LOG2=0, PULSE_W=4, DIR_SETUP=6, MIN_PERIOD=8.
- Reset: assert rst, hold en=1, period=20 → all outputs 0 and pos=0. After release with dir=0, first step_out rise exactly 3 clk after release (2 capture cycles + 1).
- Steady run: en=1, dir=0, period=20 → step_out high 4 cycles, rise-to-rise 20 cycles, pos -1 per step; step_done once per step, 1 cycle before the next rise.
- Clamp and hold: period=3 → rise-to-rise 8 cycles. period=0 mid-step → that step completes, busy falls, no further rises.
- Reversal: dir 0→1 during HIGH → pulse completes and LOW completes. dir_out goes 1 on the LOW exit cycle. Next rise exactly 6 cycles later. pos then increments.
- Enable drop: en=0 on the 2nd HIGH cycle → step_out still high 4 cycles total, then LOW completes, then IDLE with busy=0.
- Async reset mid-HIGH: rst pulse → step_out=0 and pos=0 in the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the STEP/DIR pulse generator: state codes and the
// effective step period calculation.
package stepper_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_DIR_SETUP = 2'd1;
    localparam state_t ST_HIGH      = 2'd2;
    localparam state_t ST_LOW       = 2'd3;

    // Scaled period, clamped so the driver never sees steps faster than min_period.
    function automatic logic [31:0] calc_step_period(input logic [31:0] period_s,
                                                     input int          shift,
                                                     input logic [31:0] min_period);
        logic [31:0] scaled;
        scaled = period_s << shift;
        return (scaled < min_period) ? min_period : scaled;
    endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Controller-side bundle of the step pulse generator: enable/direction/period
// in, STEP/DIR plus status and position out.
interface step_pulse_gen_if #(
    parameter int WIDTH_WORK = 16,
    parameter int POS_WIDTH  = 32
);
    logic                  en;
    logic                  dir;
    logic [WIDTH_WORK-1:0] period;
    logic                  step_out;
    logic                  dir_out;
    logic                  busy;
    logic                  step_done;
    logic [POS_WIDTH-1:0]  pos;

    modport master (
        output en, dir, period,
        input  step_out, dir_out, busy, step_done, pos
    );

    modport slave (
        input  en, dir, period,
        output step_out, dir_out, busy, step_done, pos
    );
endinterface

// File: rtl/step_period_capture.sv
// Brings the asynchronously written period word into the clk domain: a value is
// accepted only when two consecutive samples agree, so torn words never pass.
module step_period_capture #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] period_in,
    output logic [WIDTH-1:0] period_s
);

    logic [WIDTH-1:0] p0_q;
    logic [WIDTH-1:0] p0_d;
    logic [WIDTH-1:0] period_s_q;
    logic [WIDTH-1:0] period_s_d;

    always_comb begin
        p0_d       = period_in;
        period_s_d = period_s_q;
        if (period_in == p0_q) begin
            period_s_d = p0_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_q       <= '0;
            period_s_q <= '0;
        end else begin
            p0_q       <= p0_d;
            period_s_q <= period_s_d;
        end
    end

    assign period_s = period_s_q;

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR generator for the external stepper driver: fixed pulse width, DIR
// setup before the first step after a reversal, clamped step period, position count.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | no step in flight, waiting for en with a nonzero period
//   ST_DIR_SETUP | dir_out just changed, holding off the next STEP rise
//   ST_HIGH      | STEP asserted for PULSE_W cycles
//   ST_LOW       | STEP low for the rest of the latched period t_q
module step_pulse_gen
    import stepper_pkg::*;
#(
    parameter int WIDTH_WORK    = 16,
    parameter int PRESCALE_LOG2 = 3,
    parameter int PULSE_W       = 100,
    parameter int DIR_SETUP     = 250,
    parameter int MIN_PERIOD    = 200,
    parameter int POS_WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    step_pulse_gen_if.slave  bus
);

    localparam int CW = WIDTH_WORK + PRESCALE_LOG2;

    localparam logic [CW-1:0]        ONE_C       = CW'(1);
    localparam logic [CW-1:0]        PULSE_W_C   = CW'(PULSE_W);
    localparam logic [CW-1:0]        DIR_SETUP_C = CW'(DIR_SETUP);
    localparam logic [POS_WIDTH-1:0] POS_ONE     = POS_WIDTH'(1);

    logic [WIDTH_WORK-1:0] period_s;
    logic [CW-1:0]         t_calc;
    logic                  go;
    logic                  decide;
    logic                  start_step;

    state_t                state_q,     state_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic [CW-1:0]         t_q,         t_d;
    logic                  step_out_q,  step_out_d;
    logic                  dir_out_q,   dir_out_d;
    logic                  busy_q,      busy_d;
    logic                  step_done_q, step_done_d;
    logic [POS_WIDTH-1:0]  pos_q,       pos_d;

    step_period_capture #(
        .WIDTH     (WIDTH_WORK)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .period_in (bus.period),
        .period_s  (period_s)
    );

    assign t_calc = CW'(calc_step_period(32'(period_s), PRESCALE_LOG2, 32'(MIN_PERIOD)));
    assign go     = bus.en && (period_s != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        t_d        = t_q;
        dir_out_d  = dir_out_q;
        pos_d      = pos_q;
        decide     = 1'b0;
        start_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                decide = 1'b1;
            end
            ST_DIR_SETUP: begin
                if (!go) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    start_step = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            ST_HIGH: begin
                // en is deliberately ignored here so a pulse is never cut short
                if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = t_q - PULSE_W_C - ONE_C;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    decide = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (decide) begin
            if (!go) begin
                state_d = ST_IDLE;
            end else if (bus.dir == dir_out_q) begin
                start_step = 1'b1;
            end else begin
                dir_out_d = bus.dir;
                state_d   = ST_DIR_SETUP;
                cnt_d     = DIR_SETUP_C - ONE_C;
            end
        end

        // The period is frozen here so later changes only affect the next step.
        if (start_step) begin
            state_d = ST_HIGH;
            cnt_d   = PULSE_W_C - ONE_C;
            t_d     = t_calc;
            pos_d   = dir_out_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
        end

        step_out_d  = (state_d == ST_HIGH);
        busy_d      = (state_d != ST_IDLE);
        step_done_d = (state_d == ST_LOW) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            t_q         <= '0;
            step_out_q  <= 1'b0;
            dir_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            pos_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_q         <= t_d;
            step_out_q  <= step_out_d;
            dir_out_q   <= dir_out_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
            pos_q       <= pos_d;
        end
    end

    assign bus.step_out  = step_out_q;
    assign bus.dir_out   = dir_out_q;
    assign bus.busy      = busy_q;
    assign bus.step_done = step_done_q;
    assign bus.pos       = pos_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: a timestamp-level reference model predicts
// every STEP rise, step_done, DIR change and busy edge; a monitor checks them.
module tb_step_pulse_gen;

    localparam int WW   = 16;
    localparam int PS   = 0;
    localparam int PW   = 4;
    localparam int DS   = 6;
    localparam int MINP = 8;
    localparam int PWID = 32;
    localparam int NMAX = 3000;

    typedef struct { int cyc; bit dir; int pos; } rise_t;
    typedef struct { int cyc; bit val; } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_err;
    bit   mon_en;

    rise_t q_rise[$];
    int    q_done[$];
    ev_t   q_dir[$];
    ev_t   q_busy[$];

    bit en_a  [NMAX+2];
    bit dir_a [NMAX+2];
    int per_a [NMAX+2];
    int ps_a  [NMAX+2];
    int n_sched;

    step_pulse_gen_if #(.WIDTH_WORK(WW), .POS_WIDTH(PWID)) bus ();

    step_pulse_gen #(
        .WIDTH_WORK    (WW),
        .PRESCALE_LOG2 (PS),
        .PULSE_W       (PW),
        .DIR_SETUP     (DS),
        .MIN_PERIOD    (MINP),
        .POS_WIDTH     (PWID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int step_period(input int p);
        int s;
        s = p << PS;
        return (s < MINP) ? MINP : s;
    endfunction

    function automatic bit go_at(input int c);
        if (c > n_sched) return 1'b0;
        return en_a[c] && (ps_a[c-1] != 0);
    endfunction

    function automatic void add_seg(input bit e, input bit d, input int p, input int len);
        for (int i = 0; i < len && n_sched < NMAX; i++) begin
            n_sched++;
            en_a[n_sched]  = e;
            dir_a[n_sched] = d;
            per_a[n_sched] = p;
        end
    endfunction

    function automatic void build(input bit directed);
        int r;
        int p;
        int len;
        n_sched = 0;
        if (directed) begin
            add_seg(1'b1, 1'b0, 20, 104);   // steady, en dropped during a pulse below
            add_seg(1'b0, 1'b0, 20, 46);
            add_seg(1'b1, 1'b0, 3, 60);     // clamped to MIN_PERIOD
            add_seg(1'b1, 1'b0, 0, 40);     // hold
            add_seg(1'b1, 1'b0, 20, 50);
            add_seg(1'b1, 1'b1, 20, 80);    // reversal
            add_seg(1'b1, 1'b0, 13, 60);
        end
        repeat (35) begin
            r   = $urandom_range(0, 9);
            p   = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 7) : $urandom_range(8, 30);
            len = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(2, 50);
            add_seg($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), p, len);
        end
        add_seg(1'b0, 1'b0, 20, 120);
    endfunction

    // Walks decision instants (edges where the generator may start something)
    // and schedules the observable events with plain timestamp arithmetic.
    function automatic void model();
        int  c;
        int  t;
        int  pos;
        int  prev;
        bit  dout;
        bit  busy;
        bit  aborted;
        ps_a[0] = 0;
        for (int k = 1; k <= n_sched; k++) begin
            prev    = (k == 1) ? 0 : per_a[k-1];
            ps_a[k] = (per_a[k] == prev) ? per_a[k] : ps_a[k-1];
        end
        q_rise.delete(); q_done.delete(); q_dir.delete(); q_busy.delete();
        c = 1; dout = 1'b0; pos = 0; busy = 1'b0;
        while (c <= n_sched) begin
            if (!go_at(c)) begin
                if (busy) begin q_busy.push_back('{c, 1'b0}); busy = 1'b0; end
                c++;
                continue;
            end
            if (!busy) begin q_busy.push_back('{c, 1'b1}); busy = 1'b1; end
            if (dir_a[c] != dout) begin
                dout = dir_a[c];
                q_dir.push_back('{c, dout});
                aborted = 1'b0;
                for (int k = 1; k <= DS; k++) begin
                    if (!go_at(c + k)) begin
                        q_busy.push_back('{c + k, 1'b0});
                        busy    = 1'b0;
                        c       = c + k + 1;
                        aborted = 1'b1;
                        break;
                    end
                end
                if (aborted) continue;
                c = c + DS;
            end
            pos = dout ? pos + 1 : pos - 1;
            t   = step_period(ps_a[c-1]);
            q_rise.push_back('{c, dout, pos});
            q_done.push_back(c + t - 1);
            c = c + t;
        end
    endfunction

    // ---------------- monitor ----------------
    bit prev_step, prev_dir, prev_busy;
    int high_start;

    always @(negedge clk) begin
        rise_t r;
        ev_t   e;
        int    d;
        if (rst || !mon_en) begin
            prev_step = bus.step_out;
            prev_dir  = bus.dir_out;
            prev_busy = bus.busy;
        end else begin
            if (bus.step_out && !prev_step) begin
                if (q_rise.size() == 0) begin
                    chk("unexpected_step_rise", cyc, -1);
                end else begin
                    r = q_rise.pop_front();
                    chk("rise_cycle", cyc, r.cyc);
                    chk("rise_dir_out", bus.dir_out, r.dir);
                    chk("rise_pos", int'($signed(bus.pos)), r.pos);
                end
                high_start = cyc;
            end
            if (!bus.step_out && prev_step) chk("pulse_width", cyc - high_start, PW);
            if (bus.step_done) begin
                if (q_done.size() == 0) begin
                    chk("unexpected_step_done", cyc, -1);
                end else begin
                    d = q_done.pop_front();
                    chk("step_done_cycle", cyc, d);
                end
            end
            if (bus.dir_out != prev_dir) begin
                chk("dir_change_step_low", bus.step_out, 0);
                if (q_dir.size() == 0) begin
                    chk("unexpected_dir_change", cyc, -1);
                end else begin
                    e = q_dir.pop_front();
                    chk("dir_change_cycle", cyc, e.cyc);
                    chk("dir_change_value", bus.dir_out, e.val);
                end
            end
            if (bus.busy != prev_busy) begin
                if (q_busy.size() == 0) begin
                    chk("unexpected_busy_edge", cyc, -1);
                end else begin
                    e = q_busy.pop_front();
                    chk("busy_edge_cycle", cyc, e.cyc);
                    chk("busy_edge_value", bus.busy, e.val);
                end
            end
            prev_step = bus.step_out;
            prev_dir  = bus.dir_out;
            prev_busy = bus.busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int k);
        bus.en     = en_a[k];
        bus.dir    = dir_a[k];
        bus.period = WW'(per_a[k]);
    endtask

    task automatic run_schedule(input bit directed);
        build(directed);
        model();
        drive(1);
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 1; k <= n_sched; k++) begin
            drive(k);
            @(posedge clk); #1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("leftover_rises", q_rise.size(), 0);
        chk("leftover_done", q_done.size(), 0);
        chk("leftover_dir", q_dir.size(), 0);
        chk("leftover_busy", q_busy.size(), 0);
        chk("final_busy", bus.busy, 0);
        mon_en = 1'b0;
    endtask

    initial begin
        bit seen;
        n_chk = 0; n_err = 0; mon_en = 1'b0;
        rst = 1'b1;
        bus.en = 1'b1; bus.dir = 1'b0; bus.period = WW'(20);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_step_out", bus.step_out, 0);
        chk("reset_dir_out", bus.dir_out, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_step_done", bus.step_done, 0);
        chk("reset_pos", bus.pos, 0);

        run_schedule(1'b1);

        // asynchronous reset in the middle of a pulse
        bus.en = 1'b1; bus.dir = 1'b0; bus.period = WW'(20);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (bus.step_out) seen = 1'b1;
        end
        chk("async_rst_step_seen", seen, 1);
        @(posedge clk); #2;
        chk("async_rst_pre_step_out", bus.step_out, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_step_out", bus.step_out, 0);
        chk("async_rst_pos", bus.pos, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_dir_out", bus.dir_out, 0);
        repeat (2) @(posedge clk);

        run_schedule(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
